// File: rtl/store_buffer_pkg.sv
// Shared definitions for the data-memory store buffer: default sizing,
// word-offset constant, entry layout and the word-address compare helper.
package hex_mem_pkg;

    localparam int SB_DEPTH_DEF = 4;
    localparam int SB_AW_DEF    = 32;
    localparam int SB_DW_DEF    = 32;
    localparam int WORD_LSB     = 2;

    typedef struct packed {
        logic [SB_AW_DEF-1:0] addr;
        logic [SB_DW_DEF-1:0] data;
        logic                 valid;
    } sb_entry_t;

    localparam sb_entry_t ENTRY_CLR = '{
        addr:  {SB_AW_DEF{1'b0}},
        data:  {SB_DW_DEF{1'b0}},
        valid: 1'b0
    };

    // Byte offsets within a word are ignored; xor/shift keeps every bit live.
    function automatic logic word_match(input logic [SB_AW_DEF-1:0] a,
                                        input logic [SB_AW_DEF-1:0] b);
        logic [SB_AW_DEF-1:0] diff;
        diff = a ^ b;
        return ((diff >> WORD_LSB) == {SB_AW_DEF{1'b0}});
    endfunction

endpackage

// File: rtl/store_buffer_if.sv
// Core/memory side bundle of the store buffer. master = core plus data memory,
// slave = the store buffer itself.
interface store_buffer_if #(
    parameter int AW    = 32,
    parameter int DW    = 32,
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH + 1);

    logic          st_valid;
    logic [AW-1:0] st_addr;
    logic [DW-1:0] st_data;
    logic          st_ready;
    logic          ld_valid;
    logic [AW-1:0] ld_addr;
    logic          ld_hit;
    logic [DW-1:0] ld_data;
    logic          ld_stall;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_ack;
    logic          empty;
    logic [CW-1:0] count;

    modport master (
        output st_valid, st_addr, st_data, ld_valid, ld_addr, mem_ack,
        input  st_ready, ld_hit, ld_data, ld_stall, mem_we, mem_addr, mem_wdata,
               empty, count
    );

    modport slave (
        input  st_valid, st_addr, st_data, ld_valid, ld_addr, mem_ack,
        output st_ready, ld_hit, ld_data, ld_stall, mem_we, mem_addr, mem_wdata,
               empty, count
    );

endinterface

// File: rtl/store_buffer_match.sv
// Load-vs-buffered-store comparator array with youngest-first data select,
// where age is measured backwards from the write pointer.
module store_buffer_match
    import hex_mem_pkg::*;
#(
    parameter int DEPTH = SB_DEPTH_DEF,
    parameter int AW    = SB_AW_DEF,
    parameter int DW    = SB_DW_DEF
) (
    input  sb_entry_t                    entries [DEPTH],
    input  logic [$clog2(DEPTH)-1:0]     wr_ptr,
    input  logic [AW-1:0]                ld_addr,
    output logic                         any_match,
    output logic [DW-1:0]                sel_data
);

    localparam int PW = $clog2(DEPTH);

    logic [DEPTH-1:0] match_s;
    logic [PW-1:0]    idx_s;

    // One word-address comparator per valid entry
    always_comb begin
        match_s = {DEPTH{1'b0}};
        for (int i = 0; i < DEPTH; i++) begin
            match_s[i] = entries[i].valid && word_match(entries[i].addr, ld_addr);
        end
    end

    // Sweep oldest to youngest so the youngest matching entry is written last
    always_comb begin
        sel_data = {DW{1'b0}};
        idx_s    = {PW{1'b0}};
        for (int k = DEPTH; k >= 1; k--) begin
            idx_s    = wr_ptr - PW'(k);
            sel_data = match_s[idx_s] ? entries[idx_s].data : sel_data;
        end
    end

    assign any_match = |match_s;

endmodule

// File: rtl/store_buffer.sv
// Posted-write store buffer between the core's store port and data memory.
// Optional macro STORE_FWD_EN: forward youngest matching store to loads
// instead of stalling them.
module store_buffer
    import hex_mem_pkg::*;
#(
    parameter int DEPTH = SB_DEPTH_DEF,
    parameter int AW    = SB_AW_DEF,
    parameter int DW    = SB_DW_DEF
) (
    input  logic             clk,
    input  logic             reset,
    store_buffer_if.slave    bus
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    sb_entry_t       entry_r [DEPTH];
    logic [PW-1:0]   wr_ptr_r;
    logic [PW-1:0]   rd_ptr_r;
    logic [CW-1:0]   count_r;

    logic            full_s;
    logic            empty_s;
    logic            push_s;
    logic            pop_s;
    logic            any_match_s;
    logic [DW-1:0]   sel_data_s;

    // Full blocks a push even when a pop happens in the same cycle, keeping
    // st_ready free of any path from mem_ack.
    assign full_s  = (count_r == CW'(DEPTH));
    assign empty_s = (count_r == {CW{1'b0}});
    assign push_s  = bus.st_valid && !full_s;
    assign pop_s   = !empty_s && bus.mem_ack;

    // Pointers and occupancy
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PW'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Entry storage; push and pop never target the same slot in one cycle
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                entry_r[i] <= ENTRY_CLR;
            end
        end else begin
            if (push_s) begin
                entry_r[wr_ptr_r] <= '{addr: bus.st_addr, data: bus.st_data, valid: 1'b1};
            end
            if (pop_s) begin
                entry_r[rd_ptr_r].valid <= 1'b0;
            end
        end
    end

    store_buffer_match #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .DW    (DW)
    ) u_match (
        .entries   (entry_r),
        .wr_ptr    (wr_ptr_r),
        .ld_addr   (bus.ld_addr),
        .any_match (any_match_s),
        .sel_data  (sel_data_s)
    );

    assign bus.st_ready  = !full_s;
    assign bus.empty     = empty_s;
    assign bus.count     = count_r;
    assign bus.mem_we    = !empty_s;
    assign bus.mem_addr  = entry_r[rd_ptr_r].addr;
    assign bus.mem_wdata = entry_r[rd_ptr_r].data;

    // Load hazard resolution against buffered stores
    always_comb begin
        bus.ld_hit   = 1'b0;
        bus.ld_data  = {DW{1'b0}};
        bus.ld_stall = 1'b0;
`ifdef STORE_FWD_EN
        if (bus.ld_valid && any_match_s) begin
            bus.ld_hit  = 1'b1;
            bus.ld_data = sel_data_s;
        end else begin
            bus.ld_hit  = 1'b0;
            bus.ld_data = {DW{1'b0}};
        end
`else
        bus.ld_stall = bus.ld_valid && any_match_s;
`endif
    end

endmodule

// File: tb/tb_store_buffer.sv
// Directed, table-driven bench for store_buffer (DEPTH=4, AW=DW=32); checks
// occupancy, drain order, full/push-pop corners, load hazards and mid-run reset.
module tb_store_buffer;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    store_buffer_if #(.AW(32), .DW(32), .DEPTH(4)) bus ();

    store_buffer #(.DEPTH(4), .AW(32), .DW(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic        sv;
        logic [31:0] sa;
        logic [31:0] sd;
        logic        lv;
        logic [31:0] la;
        logic        ack;
        logic        e_rdy;
        logic        e_we;
        logic [31:0] e_addr;
        logic [31:0] e_data;
        logic [2:0]  e_cnt;
        logic        e_match;
        logic [31:0] e_ld;
    } vec_t;

    function automatic vec_t mk(logic sv, logic [31:0] sa, logic [31:0] sd,
                                logic lv, logic [31:0] la, logic ack,
                                logic rdy, logic we, logic [31:0] ea, logic [31:0] ed,
                                logic [2:0] cnt, logic m, logic [31:0] ld);
        vec_t v;
        v.sv = sv; v.sa = sa; v.sd = sd; v.lv = lv; v.la = la; v.ack = ack;
        v.e_rdy = rdy; v.e_we = we; v.e_addr = ea; v.e_data = ed;
        v.e_cnt = cnt; v.e_match = m; v.e_ld = ld;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive_idle();
        bus.st_valid = 1'b0; bus.st_addr = 32'd0; bus.st_data = 32'd0;
        bus.ld_valid = 1'b0; bus.ld_addr = 32'd0; bus.mem_ack = 1'b0;
    endtask

    task automatic check_status(input string tag, input logic rdy, input logic we,
                                input logic [2:0] cnt);
        chk({tag, " count"},    32'(bus.count),    32'(cnt));
        chk({tag, " empty"},    32'(bus.empty),    32'(cnt == 3'd0));
        chk({tag, " st_ready"}, 32'(bus.st_ready), 32'(rdy));
        chk({tag, " mem_we"},   32'(bus.mem_we),   32'(we));
    endtask

    // Drive one vector, check at the falling edge, then let the rising edge commit it.
    task automatic apply(input vec_t v, input string tag);
        bus.st_valid = v.sv; bus.st_addr = v.sa; bus.st_data = v.sd;
        bus.ld_valid = v.lv; bus.ld_addr = v.la; bus.mem_ack = v.ack;
        @(negedge clk);
        check_status(tag, v.e_rdy, v.e_we, v.e_cnt);
        if (v.e_we) begin
            chk({tag, " mem_addr"},  bus.mem_addr,  v.e_addr);
            chk({tag, " mem_wdata"}, bus.mem_wdata, v.e_data);
        end
`ifdef STORE_FWD_EN
        chk({tag, " ld_hit"},   32'(bus.ld_hit),   32'(v.e_match));
        chk({tag, " ld_data"},  bus.ld_data,       v.e_match ? v.e_ld : 32'd0);
        chk({tag, " ld_stall"}, 32'(bus.ld_stall), 32'd0);
`else
        chk({tag, " ld_stall"}, 32'(bus.ld_stall), 32'(v.e_match));
        chk({tag, " ld_hit"},   32'(bus.ld_hit),   32'd0);
        chk({tag, " ld_data"},  bus.ld_data,       32'd0);
`endif
        @(posedge clk);
        #1;
    endtask

    vec_t tbl [18];
    vec_t t5  [6];

    initial begin
        drive_idle();

        tbl[0]  = mk(1'b1, 32'd100, 32'd7,    1'b0, 32'd0,   1'b1, 1'b1, 1'b0, 32'd0,   32'd0,    3'd0, 1'b0, 32'd0);
        tbl[1]  = mk(1'b0, 32'd0,   32'd0,    1'b0, 32'd0,   1'b1, 1'b1, 1'b1, 32'd100, 32'd7,    3'd1, 1'b0, 32'd0);
        tbl[2]  = mk(1'b0, 32'd0,   32'd0,    1'b0, 32'd0,   1'b0, 1'b1, 1'b0, 32'd0,   32'd0,    3'd0, 1'b0, 32'd0);
        tbl[3]  = mk(1'b1, 32'd0,   32'hA0,   1'b0, 32'd0,   1'b0, 1'b1, 1'b0, 32'd0,   32'd0,    3'd0, 1'b0, 32'd0);
        tbl[4]  = mk(1'b1, 32'd4,   32'hA1,   1'b0, 32'd0,   1'b0, 1'b1, 1'b1, 32'd0,   32'hA0,   3'd1, 1'b0, 32'd0);
        tbl[5]  = mk(1'b1, 32'd8,   32'hA2,   1'b1, 32'd4,   1'b0, 1'b1, 1'b1, 32'd0,   32'hA0,   3'd2, 1'b1, 32'hA1);
        tbl[6]  = mk(1'b1, 32'd12,  32'hA3,   1'b0, 32'd0,   1'b0, 1'b1, 1'b1, 32'd0,   32'hA0,   3'd3, 1'b0, 32'd0);
        tbl[7]  = mk(1'b1, 32'd16,  32'hA4,   1'b1, 32'd16,  1'b0, 1'b0, 1'b1, 32'd0,   32'hA0,   3'd4, 1'b0, 32'd0);
        tbl[8]  = mk(1'b1, 32'd16,  32'hA4,   1'b0, 32'd0,   1'b1, 1'b0, 1'b1, 32'd0,   32'hA0,   3'd4, 1'b0, 32'd0);
        tbl[9]  = mk(1'b1, 32'd16,  32'hA4,   1'b1, 32'd8,   1'b1, 1'b1, 1'b1, 32'd4,   32'hA1,   3'd3, 1'b1, 32'hA2);
        tbl[10] = mk(1'b0, 32'd0,   32'd0,    1'b0, 32'd0,   1'b1, 1'b1, 1'b1, 32'd8,   32'hA2,   3'd3, 1'b0, 32'd0);
        tbl[11] = mk(1'b0, 32'd0,   32'd0,    1'b0, 32'd0,   1'b1, 1'b1, 1'b1, 32'd12,  32'hA3,   3'd2, 1'b0, 32'd0);
        tbl[12] = mk(1'b0, 32'd0,   32'd0,    1'b0, 32'd0,   1'b1, 1'b1, 1'b1, 32'd16,  32'hA4,   3'd1, 1'b0, 32'd0);
        tbl[13] = mk(1'b0, 32'd0,   32'd0,    1'b0, 32'd0,   1'b1, 1'b1, 1'b0, 32'd0,   32'd0,    3'd0, 1'b0, 32'd0);
        tbl[14] = mk(1'b1, 32'd200, 32'h55,   1'b1, 32'd200, 1'b0, 1'b1, 1'b0, 32'd0,   32'd0,    3'd0, 1'b0, 32'd0);
        tbl[15] = mk(1'b1, 32'd204, 32'h66,   1'b1, 32'd202, 1'b1, 1'b1, 1'b1, 32'd200, 32'h55,   3'd1, 1'b1, 32'h55);
        tbl[16] = mk(1'b0, 32'd0,   32'd0,    1'b1, 32'd200, 1'b1, 1'b1, 1'b1, 32'd204, 32'h66,   3'd1, 1'b0, 32'd0);
        tbl[17] = mk(1'b0, 32'd0,   32'd0,    1'b0, 32'd0,   1'b0, 1'b1, 1'b0, 32'd0,   32'd0,    3'd0, 1'b0, 32'd0);

        // Two stores to the same word; loads must see the younger one
        t5[0] = mk(1'b1, 32'd96, 32'd1, 1'b0, 32'd0,  1'b0, 1'b1, 1'b0, 32'd0,  32'd0, 3'd0, 1'b0, 32'd0);
        t5[1] = mk(1'b1, 32'd96, 32'd9, 1'b1, 32'd96, 1'b0, 1'b1, 1'b1, 32'd96, 32'd1, 3'd1, 1'b1, 32'd1);
        t5[2] = mk(1'b0, 32'd0,  32'd0, 1'b1, 32'd96, 1'b0, 1'b1, 1'b1, 32'd96, 32'd1, 3'd2, 1'b1, 32'd9);
        t5[3] = mk(1'b0, 32'd0,  32'd0, 1'b1, 32'd97, 1'b1, 1'b1, 1'b1, 32'd96, 32'd1, 3'd2, 1'b1, 32'd9);
        t5[4] = mk(1'b0, 32'd0,  32'd0, 1'b1, 32'd96, 1'b1, 1'b1, 1'b1, 32'd96, 32'd9, 3'd1, 1'b1, 32'd9);
        t5[5] = mk(1'b0, 32'd0,  32'd0, 1'b1, 32'd96, 1'b0, 1'b1, 1'b0, 32'd0,  32'd0, 3'd0, 1'b0, 32'd0);

        // Reset held low for two cycles
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        check_status("reset", 1'b1, 1'b0, 3'd0);
        chk("reset ld_hit",   32'(bus.ld_hit),   32'd0);
        chk("reset ld_stall", 32'(bus.ld_stall), 32'd0);
        chk("reset ld_data",  bus.ld_data,       32'd0);
        @(posedge clk);
        #1;

        for (int i = 0; i < 18; i++) begin
            apply(tbl[i], $sformatf("vec%0d", i));
        end

        for (int i = 0; i < 6; i++) begin
            apply(t5[i], $sformatf("hazard%0d", i));
        end

        // Mid-run reset drops pending stores
        apply(mk(1'b1, 32'd400, 32'd4, 1'b0, 32'd0, 1'b0, 1'b1, 1'b0, 32'd0,   32'd0, 3'd0, 1'b0, 32'd0), "drop0");
        apply(mk(1'b1, 32'd404, 32'd5, 1'b0, 32'd0, 1'b0, 1'b1, 1'b1, 32'd400, 32'd4, 3'd1, 1'b0, 32'd0), "drop1");
        drive_idle();
        @(negedge clk);
        chk("pre-reset count", 32'(bus.count), 32'd2);
        reset = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        check_status("midreset", 1'b1, 1'b0, 3'd0);
        @(posedge clk);
        #1;
        apply(mk(1'b0, 32'd0,   32'd0,    1'b1, 32'd400, 1'b1, 1'b1, 1'b0, 32'd0,   32'd0,    3'd0, 1'b0, 32'd0), "post0");
        apply(mk(1'b1, 32'd500, 32'h50,   1'b0, 32'd0,   1'b1, 1'b1, 1'b0, 32'd0,   32'd0,    3'd0, 1'b0, 32'd0), "post1");
        apply(mk(1'b0, 32'd0,   32'd0,    1'b0, 32'd0,   1'b1, 1'b1, 1'b1, 32'd500, 32'h50,   3'd1, 1'b0, 32'd0), "post2");
        apply(mk(1'b0, 32'd0,   32'd0,    1'b0, 32'd0,   1'b0, 1'b1, 1'b0, 32'd0,   32'd0,    3'd0, 1'b0, 32'd0), "post3");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
